mux8_rr_arbiter: RTL and testbench

- Shares one 1-bit output channel between 8 requesters using round-robin arbitration.
- Generates the select code and one-hot grant for an 8-to-1 datapath mux and contains that mux.
- A grant is held until the owner drops its request or a hold limit expires.
- Sits between 8 serial producers and a single serial consumer.

---
 rtl/mux8_arb_pkg.sv | 33 +++
 rtl/rr_pick8.sv | 20 ++
 rtl/mux8_rr_arbiter.sv | 100 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared types and the rotate-priority search used by the 8-way round-robin arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] win;
  } pick_t;

  // First set request found when scanning ptr, ptr+1, ... with wrap from 7 to 0.
  function automatic pick_t rr_next(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.win   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority encoder: picks the first requester at or after ptr.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             found
);

  pick_t pick;

  always_comb begin
    pick = rr_next(req, ptr);
  end

  assign win   = pick.win;
  assign found = pick.found;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one serial output channel between 8 requesters,
// with a bounded hold time per grant and the 8:1 data mux for the owner.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [SEL_W-1:0] pick_win;
  logic             pick_found;
  logic             release_d;
  logic             out_d;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .found (pick_found)
  );

  // Owner dropping its request takes precedence over hold-limit expiry;
  // both lead to the same release.
  always_comb begin
    release_d = 1'b0;
    if (state_q == HOLD) begin
      release_d = !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= HOLD;
            gnt_q   <= N_REQ'(1) << pick_win;
            sel_q   <= pick_win;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (release_d) begin
            // Pointer moves past the owner so a pre-empted requester drops to lowest priority.
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + SEL_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out_d = 1'b0;
    if (busy_q) begin
      out_d = data[sel_q];
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out       = out_d;
  assign out_valid = busy_q & req[sel_q];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter with MAX_HOLD of 16, 2 and 1.
module tb_mux8_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] req0 = '0, data0 = '0, gnt0;
  logic [7:0] req1 = '0, data1 = '0, gnt1;
  logic [7:0] req2 = '0, data2 = '0, gnt2;
  logic [2:0] sel0, sel1, sel2;
  logic       out0, out1, out2, ov0, ov1, ov2, busy0, busy1, busy2;

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .req(req0), .data(data0), .gnt(gnt0), .sel(sel0),
    .out(out0), .out_valid(ov0), .busy(busy0));

  mux8_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .req(req1), .data(data1), .gnt(gnt1), .sel(sel1),
    .out(out1), .out_valid(ov1), .busy(busy1));

  mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req(req2), .data(data2), .gnt(gnt2), .sel(sel2),
    .out(out2), .out_valid(ov2), .busy(busy2));

  typedef struct {
    int         cyc;
    int         d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic       ov;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] dpat     = 8'h69;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s.%s cyc=%0d actual=%h required=%h", nm, fld, cyc, act, req_v);
    end
  endtask

  // Drive one cycle of inputs to DUT d and queue the outputs expected at this cycle's negedge.
  task automatic step(input int d, input logic [7:0] r, input logic rv,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb,
                      input string nm);
    exp_t       e;
    logic [7:0] dat;
    @(posedge clk);
    #1;
    dpat = {dpat[6:0], dpat[7]};
    dat  = rv ? 8'hFF : dpat;
    rst  = rv;
    case (d)
      0: begin req0 = r; data0 = dat; end
      1: begin req1 = r; data1 = dat; end
      default: begin req2 = r; data2 = dat; end
    endcase
    e.cyc  = cyc;
    e.d    = d;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = eb;
    e.out  = eb ? dat[es] : 1'b0;
    e.ov   = eb & r[es];
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare against queued expectations.
  initial begin
    exp_t       e;
    logic [7:0] ag;
    logic [2:0] as;
    logic       ab, ao, av;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.d)
          0: begin ag = gnt0; as = sel0; ab = busy0; ao = out0; av = ov0; end
          1: begin ag = gnt1; as = sel1; ab = busy1; ao = out1; av = ov1; end
          default: begin ag = gnt2; as = sel2; ab = busy2; ao = out2; av = ov2; end
        endcase
        if (e.cyc != cyc) begin
          chk(e.nm, "stale_cycle", 8'(cyc), 8'(e.cyc));
        end else begin
          chk(e.nm, "gnt", ag, e.gnt);
          chk(e.nm, "sel", {5'b0, as}, {5'b0, e.sel});
          chk(e.nm, "busy", {7'b0, ab}, {7'b0, e.busy});
          chk(e.nm, "out", {7'b0, ao}, {7'b0, e.out});
          chk(e.nm, "out_valid", {7'b0, av}, {7'b0, e.ov});
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] w;

    // Reset state on all three instances
    step(0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rst_dut16");
    step(1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rst_dut2");
    step(2, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rst_dut1");

    // Single requester 2 for five busy cycles, then ptr=3 picks 3 over 0
    step(0, 8'h04, 1'b0, 8'h00, 3'd0, 1'b0, "single_idle");
    repeat (4) step(0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, "single_hold");
    step(0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b1, "single_drop");
    step(0, 8'h09, 1'b0, 8'h00, 3'd2, 1'b0, "single_rel");
    step(0, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, "ptr3_grant");
    step(0, 8'h20, 1'b0, 8'h00, 3'd3, 1'b0, "ptr3_rel");
    step(0, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, "r5_grant");

    // Wrap: ptr=6 with req 0x81 serves 7, then 0, leaving ptr=1
    step(0, 8'h81, 1'b0, 8'h00, 3'd5, 1'b0, "r5_rel");
    step(0, 8'h01, 1'b0, 8'h80, 3'd7, 1'b1, "wrap_g7");
    step(0, 8'h01, 1'b0, 8'h00, 3'd7, 1'b0, "wrap_gap");
    step(0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, "wrap_g0");
    step(0, 8'h03, 1'b0, 8'h00, 3'd0, 1'b0, "wrap_rel0");
    step(0, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, "ptr1_grant");

    // Non-owner noise on req[5] while requester 1 holds
    step(0, 8'h02, 1'b0, 8'h00, 3'd1, 1'b0, "ptr1_rel");
    step(0, 8'h22, 1'b0, 8'h02, 3'd1, 1'b1, "noise");
    step(0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, "noise");
    step(0, 8'h22, 1'b0, 8'h02, 3'd1, 1'b1, "noise");
    step(0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, "noise");
    step(0, 8'h20, 1'b0, 8'h02, 3'd1, 1'b1, "noise_drop");
    step(0, 8'h20, 1'b0, 8'h00, 3'd1, 1'b0, "noise_gap");
    step(0, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, "noise_g5");

    // Pre-emption of requester 3 after 16 cycles, then re-grant after one idle cycle
    step(0, 8'h08, 1'b0, 8'h00, 3'd5, 1'b0, "noise_rel");
    repeat (16) step(0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "preempt_hold");
    step(0, 8'h08, 1'b0, 8'h00, 3'd3, 1'b0, "preempt_gap");
    repeat (6) step(0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "regrant");

    // Asynchronous reset while hold_cnt=7, then requester 4 must get a full 16-cycle hold
    step(0, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, "async_rst");
    step(0, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, "rst_rel");
    repeat (16) step(0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, "g4_hold");
    step(0, 8'h00, 1'b0, 8'h00, 3'd4, 1'b0, "g4_preempt");

    // Fairness with MAX_HOLD=2: 0..7 then 0, two busy cycles and one gap each
    step(1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, "fair_start");
    for (int i = 0; i < 9; i++) begin
      w = 3'(i % 8);
      step(1, 8'hFF, 1'b0, 8'h01 << w, w, 1'b1, "fair_hold");
      step(1, 8'hFF, 1'b0, 8'h01 << w, w, 1'b1, "fair_hold");
      step(1, 8'hFF, 1'b0, 8'h00, w, 1'b0, "fair_gap");
    end
    step(1, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, "fair_end");
    step(1, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, "fair_rel");

    // MAX_HOLD=1: every grant lasts exactly one cycle
    step(2, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, "mh1_start");
    for (int i = 0; i < 3; i++) begin
      w = 3'(i);
      step(2, 8'hFF, 1'b0, 8'h01 << w, w, 1'b1, "mh1_grant");
      step(2, 8'hFF, 1'b0, 8'h00, w, 1'b0, "mh1_gap");
    end
    step(2, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, "mh1_g3");
    step(2, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, "mh1_rel");

    repeat (2) @(negedge clk);
    chk("scoreboard", "leftover", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
